// File: rtl/serial_twos_comp_mc.sv
// Multi-lane, word-framed, bit-serial two's-complement unit.
// Each lane passes or negates its LSB-first word; flags ovf and framing errors.
module serial_twos_comp_mc #(
  parameter int CH     = 4,
  parameter int WORD_W = 8
) (
  input  logic          t_clk,
  input  logic          r,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic [CH-1:0] i,
  input  logic [CH-1:0] neg,
  output logic [CH-1:0] y,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic [CH-1:0] ovf,
  output logic          frame_err
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CH-1:0] seen_q, seen_d;
  logic [CH-1:0] neg_q, neg_d;

  logic [CH-1:0] y_q, y_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;
  logic [CH-1:0] ovf_q, ovf_d;
  logic          frame_err_q, frame_err_d;

  logic          fb, act, accept, stray, early, is_last;
  logic [CW-1:0] pos;
  logic [CH-1:0] neg_eff, seen_eff;

  // Beat classification; a first beat restarts the word at position 0
  always_comb begin
    fb       = in_valid & in_first;
    act      = (state_q == ACTIVE);
    accept   = fb | (in_valid & act);
    stray    = in_valid & ~in_first & ~act;
    early    = fb & act & (cnt_q != '0);
    pos      = fb ? '0 : cnt_q;
    is_last  = accept & (pos == LAST);
    neg_eff  = fb ? neg : neg_q;
    seen_eff = fb ? '0 : seen_q;
  end

  // State, bit counter and per-lane "seen a 1" tracking
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= '0;
      neg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state: gaps hold everything, a completed word returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    neg_d   = neg_q;
    if (fb) begin
      state_d = ACTIVE;
      cnt_d   = CW'(1);
      neg_d   = neg;
      seen_d  = i;
    end else if (accept) begin
      seen_d = seen_q | i;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Outputs: copy up to the first 1, invert afterwards on negating lanes
  always_comb begin
    y_d         = accept ? (i ^ (neg_eff & seen_eff)) : y_q;
    out_valid_d = accept;
    out_first_d = fb;
    out_last_d  = is_last;
    ovf_d       = is_last ? (neg_eff & i & ~seen_eff) : '0;
    frame_err_d = stray | early;
  end

  // Registered outputs
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Directed bench for serial_twos_comp_mc (CH=4, WORD_W=8).
// Expected words are hand-computed two's-complement results.
module tb_serial_twos_comp_mc;

  logic       t_clk = 1'b0;
  logic       r = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_first = 1'b0;
  logic [3:0] i = '0;
  logic [3:0] neg = '0;
  logic [3:0] y;
  logic       out_valid, out_first, out_last;
  logic [3:0] ovf;
  logic       frame_err;

  int vectors = 0;
  int errs = 0;

  serial_twos_comp_mc #(.CH(4), .WORD_W(8)) dut (
    .t_clk(t_clk), .r(r),
    .in_valid(in_valid), .in_first(in_first),
    .i(i), .neg(neg),
    .y(y), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last),
    .ovf(ovf), .frame_err(frame_err)
  );

  always #5 t_clk = ~t_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic f,
                      input logic [3:0] d, input logic [3:0] n);
    in_valid = v;
    in_first = f;
    i        = d;
    neg      = n;
    @(posedge t_clk);
    #1;
  endtask

  // wv/ev pack lane k in bits [8k+7:8k]; nbits<8 sends a partial word
  task automatic word(input string tag, input logic [31:0] wv,
                      input logic [3:0] n, input logic [31:0] ev,
                      input logic [3:0] eovf, input int nbits,
                      input int gap_after, input logic efe);
    logic [3:0] d, e;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < 4; k++) begin
        d[k] = wv[8*k+b];
        e[k] = ev[8*k+b];
      end
      step(1'b1, b == 0, d, n);
      chk($sformatf("%s y b%0d", tag, b), 32'(y), 32'(e));
      chk($sformatf("%s vld b%0d", tag, b), 32'(out_valid), 32'd1);
      chk($sformatf("%s first b%0d", tag, b), 32'(out_first), 32'(b == 0));
      chk($sformatf("%s last b%0d", tag, b), 32'(out_last), 32'(b == 7));
      chk($sformatf("%s ovf b%0d", tag, b), 32'(ovf),
          (b == 7) ? 32'(eovf) : 32'd0);
      chk($sformatf("%s ferr b%0d", tag, b), 32'(frame_err),
          (b == 0) ? 32'(efe) : 32'd0);
      if (b == gap_after) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b1, 4'hF, 4'h0);
          chk($sformatf("%s gap vld %0d", tag, g), 32'(out_valid), 32'd0);
          chk($sformatf("%s gap y %0d", tag, g), 32'(y), 32'(e));
          chk($sformatf("%s gap ferr %0d", tag, g), 32'(frame_err), 32'd0);
        end
      end
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge t_clk);
    #1;
    chk("reset outs", {y, out_valid, out_first, out_last, ovf, frame_err}, 0);
    r = 1'b0;
    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk("idle vld", 32'(out_valid), 32'd0);

    // 1: 0x06 negated -> 0xFA
    word("t1", 32'h0000_0006, 4'b0001, 32'h0000_00FA, 4'b0000, 8, -1, 1'b0);
    // 2: all lanes negated, lane2 is -128 -> ovf
    word("t2", 32'h7F80_0001, 4'b1111, 32'h8180_00FF, 4'b0100, 8, -1, 1'b0);
    // 3: pass then back-to-back negate
    word("t3a", 32'h0000_0035, 4'b0000, 32'h0000_0035, 4'b0000, 8, -1, 1'b0);
    word("t3b", 32'h0000_0035, 4'b0001, 32'h0000_00CB, 4'b0000, 8, -1, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk("t3 idle vld", 32'(out_valid), 32'd0);
    chk("t3 idle ferr", 32'(frame_err), 32'd0);

    // 4: three-cycle gap after bit 3
    word("t4", 32'h0000_0006, 4'b0001, 32'h0000_00FA, 4'b0000, 8, 3, 1'b0);

    // 5: premature first at bit 4, then a full word
    word("t5p", 32'h0000_0006, 4'b0001, 32'h0000_00FA, 4'b0000, 4, -1, 1'b0);
    word("t5", 32'h0000_0001, 4'b0001, 32'h0000_00FF, 4'b0000, 8, -1, 1'b1);
    step(1'b1, 1'b0, 4'h1, 4'h1);
    chk("stray vld", 32'(out_valid), 32'd0);
    chk("stray ferr", 32'(frame_err), 32'd1);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk("stray ferr pulse", 32'(frame_err), 32'd0);

    // 6: async reset mid-word
    word("t6p", 32'h0000_0006, 4'b0001, 32'h0000_00FA, 4'b0000, 5, -1, 1'b0);
    #1 r = 1'b1;
    #1;
    chk("async rst", {y, out_valid, out_first, out_last, ovf, frame_err}, 0);
    in_valid = 1'b0;
    @(posedge t_clk);
    #1 r = 1'b0;
    step(1'b1, 1'b0, 4'h1, 4'h1);
    chk("post rst vld", 32'(out_valid), 32'd0);
    chk("post rst ferr", 32'(frame_err), 32'd1);
    word("t6", 32'h0000_0002, 4'b0001, 32'h0000_00FE, 4'b0000, 8, -1, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
